// File: rtl/uart_pkg.sv
// Shared definitions for the UART bus controller: register map,
// STATUS/CTRL bit positions and the TX sequencer state encoding.
package uart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam int ST_TX_FULL      = 0;
    localparam int ST_TX_EMPTY     = 1;
    localparam int ST_RX_EMPTY     = 2;
    localparam int ST_RX_FULL      = 3;
    localparam int ST_RX_OVERRUN   = 4;
    localparam int ST_TX_DROP      = 5;
    localparam int ST_RX_COUNT_LSB = 16;
    localparam int ST_TX_COUNT_LSB = 24;

    localparam int CTRL_RX_IRQ_EN = 0;
    localparam int CTRL_TX_IRQ_EN = 1;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_WAIT_BUSY = 2'd1,
        TX_WAIT_DONE = 2'd2
    } txState_t;

endpackage

// File: rtl/uart_bus_ctrl_sync_fifo.sv
// Single-clock FIFO with occupancy count. A push into a full FIFO is
// accepted when a pop happens in the same cycle. Head is read combinationally.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      pushData,
    input  logic                  pop,
    output logic [WIDTH-1:0]      headData,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr;
    logic [DEPTH_LOG2-1:0] rdPtr;
    logic                  doPush;
    logic                  doPop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign doPop    = pop & ~empty;
    assign doPush   = push & (~full | doPop);
    assign headData = mem[rdPtr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_bus_ctrl.sv
// Memory-mapped UART controller: TX FIFO feeding the transmitter through a
// start/busy handshake, RX FIFO capturing received bytes, STATUS with sticky
// overrun/drop flags. Optional CTRL register and interrupt under UART_IRQ_EN.
//
// TX sequencer states:
//   state        | meaning
//   TX_IDLE      | waiting for a queued byte and an idle transmitter
//   TX_WAIT_BUSY | start issued, waiting for the transmitter to raise busy
//   TX_WAIT_DONE | transmitter busy, waiting for it to finish the byte
module uart_bus_ctrl
    import uart_pkg::*;
#(
    parameter int TX_DEPTH_LOG2 = 4,
    parameter int RX_DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_en,
    input  logic        bus_we,
    input  logic [1:0]  bus_addr,
    input  logic [7:0]  bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        irq
);
    logic busRead;
    logic busWrite;
    logic dataWrite;
    logic dataRead;
    logic statusRead;

    logic [7:0]             txHead;
    logic                   txFull;
    logic                   txEmpty;
    logic [TX_DEPTH_LOG2:0] txCount;
    logic                   txPop;

    logic [7:0]             rxHead;
    logic                   rxFull;
    logic                   rxEmpty;
    logic [RX_DEPTH_LOG2:0] rxCount;
    logic                   rxPop;

    logic rxOverrun;
    logic txDrop;
    logic overrunSet;
    logic dropSet;

    txState_t state;
    txState_t nextState;
    logic     txIssue;

    logic [31:0] statusWord;
    logic [31:0] readMux;

    assign busRead    = bus_en & ~bus_we;
    assign busWrite   = bus_en & bus_we;
    assign dataWrite  = busWrite & (bus_addr == ADDR_DATA);
    assign dataRead   = busRead & (bus_addr == ADDR_DATA);
    assign statusRead = busRead & (bus_addr == ADDR_STATUS);

    assign txPop      = txIssue;
    assign rxPop      = dataRead & ~rxEmpty;
    assign dropSet    = dataWrite & txFull & ~txPop;
    assign overrunSet = rx_ready & rxFull & ~rxPop;

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(TX_DEPTH_LOG2)) txFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (dataWrite),
        .pushData (bus_wdata),
        .pop      (txPop),
        .headData (txHead),
        .full     (txFull),
        .empty    (txEmpty),
        .count    (txCount)
    );

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(RX_DEPTH_LOG2)) rxFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rx_ready),
        .pushData (rx_data),
        .pop      (rxPop),
        .headData (rxHead),
        .full     (rxFull),
        .empty    (rxEmpty),
        .count    (rxCount)
    );

    // Sticky error flags: a STATUS read clears them, a same-cycle event wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxOverrun <= 1'b0;
            txDrop    <= 1'b0;
        end else begin
            rxOverrun <= overrunSet | (rxOverrun & ~statusRead);
            txDrop    <= dropSet | (txDrop & ~statusRead);
        end
    end

    // TX sequencer state register plus registered start pulse and byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= TX_IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            state    <= nextState;
            tx_start <= txIssue;
            if (txIssue) tx_data <= txHead;
        end
    end

    // TX sequencer next state; busy rises a cycle after start, hence WAIT_BUSY.
    always_comb begin
        nextState = state;
        txIssue   = 1'b0;
        case (state)
            TX_IDLE: begin
                if (!txEmpty && !tx_busy) begin
                    txIssue   = 1'b1;
                    nextState = TX_WAIT_BUSY;
                end
            end
            TX_WAIT_BUSY: if (tx_busy)  nextState = TX_WAIT_DONE;
            TX_WAIT_DONE: if (!tx_busy) nextState = TX_IDLE;
            default:      nextState = TX_IDLE;
        endcase
    end

    // STATUS word assembly from current (pre-update) FIFO and flag state.
    always_comb begin
        statusWord                                     = '0;
        statusWord[ST_TX_FULL]                         = txFull;
        statusWord[ST_TX_EMPTY]                        = txEmpty;
        statusWord[ST_RX_EMPTY]                        = rxEmpty;
        statusWord[ST_RX_FULL]                         = rxFull;
        statusWord[ST_RX_OVERRUN]                      = rxOverrun;
        statusWord[ST_TX_DROP]                         = txDrop;
        statusWord[ST_RX_COUNT_LSB +: RX_DEPTH_LOG2+1] = rxCount;
        statusWord[ST_TX_COUNT_LSB +: TX_DEPTH_LOG2+1] = txCount;
    end

`ifdef UART_IRQ_EN
    logic rxIrqEn;
    logic txIrqEn;

    // CTRL register: interrupt enables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxIrqEn <= 1'b0;
            txIrqEn <= 1'b0;
        end else if (busWrite && (bus_addr == ADDR_CTRL)) begin
            rxIrqEn <= bus_wdata[CTRL_RX_IRQ_EN];
            txIrqEn <= bus_wdata[CTRL_TX_IRQ_EN];
        end
    end

    // Registered level interrupt: RX data pending or TX fully drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= (rxIrqEn & ~rxEmpty) | (txIrqEn & txEmpty & (state == TX_IDLE));
        end
    end
`else
    assign irq = 1'b0;
`endif

    // Read data mux by register address.
    always_comb begin
        readMux = '0;
        case (bus_addr)
            ADDR_DATA:   if (!rxEmpty) readMux = {23'b0, 1'b1, rxHead};
            ADDR_STATUS: readMux = statusWord;
`ifdef UART_IRQ_EN
            ADDR_CTRL: begin
                readMux[CTRL_RX_IRQ_EN] = rxIrqEn;
                readMux[CTRL_TX_IRQ_EN] = txIrqEn;
            end
`endif
            default:     readMux = '0;
        endcase
    end

    // Read data register: captured on a read strobe, held until the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_rdata <= '0;
        end else if (busRead) begin
            bus_rdata <= readMux;
        end
    end

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Self-checking bench for uart_bus_ctrl. Inputs change and outputs are
// sampled on the falling clock edge. A transmitter model and RX/TX byte
// queues act as scoreboards; register behaviour is driven from a vector table.
module tb_uart_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_en;
    logic        bus_we;
    logic [1:0]  bus_addr;
    logic [7:0]  bus_wdata;
    logic [31:0] bus_rdata;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        irq;

    uart_bus_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bus_en    (bus_en),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;

    logic [7:0] expTx[$];
    logic [7:0] expRx[$];

    bit   modelOn   = 1'b1;
    bit   forceBusy = 1'b0;
    logic modelBusy = 1'b0;
    int   busyLeft  = 0;
    int   cyc       = 0;
    int   fallCycle = 0;
    bit   haveFall  = 1'b0;
    int   startCount = 0;

    assign tx_busy = modelOn ? modelBusy : forceBusy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Transmitter model: busy for 20 cycles, rising the cycle after start.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            modelBusy = 1'b0;
            busyLeft  = 0;
            haveFall  = 1'b0;
        end else begin
            if (modelBusy) begin
                busyLeft--;
                if (busyLeft == 0) begin
                    modelBusy = 1'b0;
                    fallCycle = cyc;
                    haveFall  = 1'b1;
                end
            end
            if (tx_start) begin
                if (!modelOn || expTx.size() == 0) begin
                    check("tx_start_unexpected", {31'b0, tx_start}, 32'h0);
                end else begin
                    logic [7:0] b;
                    b = expTx.pop_front();
                    check("tx_data", {24'b0, tx_data}, {24'b0, b});
                    check("start_while_busy", {31'b0, modelBusy}, 32'h0);
                    // busy seen low, FSM back to IDLE, then the registered start
                    if (haveFall) check("start_gap", {31'b0, (cyc - fallCycle) >= 2}, 32'h1);
                    modelBusy = 1'b1;
                    busyLeft  = 20;
                    startCount++;
                end
            end
        end
    end

    // All bus tasks are entered on a falling edge and return on the next one.
    task automatic busWrite(input logic [1:0] a, input logic [7:0] d);
        bus_en = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        @(negedge clk);
        bus_en = 1'b0; bus_we = 1'b0;
    endtask

    task automatic busRead(input logic [1:0] a, output logic [31:0] d);
        bus_en = 1'b1; bus_we = 1'b0; bus_addr = a;
        @(negedge clk);
        bus_en = 1'b0;
        d = bus_rdata;
    endtask

    task automatic rxInject(input logic [7:0] b);
        rx_ready = 1'b1; rx_data = b;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic readData(input string name);
        logic [31:0] d;
        logic [31:0] e;
        logic [7:0]  b;
        e = 32'h0;
        if (expRx.size() > 0) begin
            b = expRx.pop_front();
            e = {23'b0, 1'b1, b};
        end
        busRead(2'd0, d);
        check(name, d, e);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [7:0]  wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] d;
    logic [31:0] e;
    logic [7:0]  b;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; bus_en = 1'b0; bus_we = 1'b0; bus_addr = 2'd0; bus_wdata = 8'h0;
        rx_ready = 1'b0; rx_data = 8'h0;

        // register map behaviour from a clean reset
        vecs.push_back('{1'b0, 2'd1, 8'h00, 32'h0000_0006});
        vecs.push_back('{1'b1, 2'd1, 8'hFF, 32'h0});
        vecs.push_back('{1'b0, 2'd1, 8'h00, 32'h0000_0006});
        vecs.push_back('{1'b0, 2'd3, 8'h00, 32'h0});
        vecs.push_back('{1'b1, 2'd3, 8'h41, 32'h0});
        vecs.push_back('{1'b0, 2'd1, 8'h00, 32'h0000_0006});
        vecs.push_back('{1'b0, 2'd0, 8'h00, 32'h0});
`ifdef UART_IRQ_EN
        vecs.push_back('{1'b1, 2'd2, 8'hFC, 32'h0});
        vecs.push_back('{1'b0, 2'd2, 8'h00, 32'h0});
        vecs.push_back('{1'b1, 2'd2, 8'h03, 32'h0});
        vecs.push_back('{1'b0, 2'd2, 8'h00, 32'h3});
        vecs.push_back('{1'b1, 2'd2, 8'h00, 32'h0});
        vecs.push_back('{1'b0, 2'd2, 8'h00, 32'h0});
`else
        vecs.push_back('{1'b1, 2'd2, 8'h03, 32'h0});
        vecs.push_back('{1'b0, 2'd2, 8'h00, 32'h0});
`endif

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_rdata",    bus_rdata, 32'h0);
        check("reset_tx_start", {31'b0, tx_start}, 32'h0);
        check("reset_tx_data",  {24'b0, tx_data}, 32'h0);
        check("reset_irq",      {31'b0, irq}, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].we) begin
                busWrite(vecs[i].addr, vecs[i].wdata);
            end else begin
                busRead(vecs[i].addr, d);
                check($sformatf("vec%0d", i), d, vecs[i].exp);
            end
        end
        repeat (5) @(negedge clk);
        check("irq_idle", {31'b0, irq}, 32'h0);

        // two bytes through the transmitter model
        expTx.push_back(8'h41);
        busWrite(2'd0, 8'h41);
        check("tx_start_early", {31'b0, tx_start}, 32'h0);
        @(negedge clk);
        check("tx_start_latency", {31'b0, tx_start}, 32'h1);
        check("tx_data_first", {24'b0, tx_data}, 32'h41);
        expTx.push_back(8'h42);
        busWrite(2'd0, 8'h42);
        check("tx_start_width", {31'b0, tx_start}, 32'h0);
        for (int k = 0; k < 300 && !(expTx.size() == 0 && !tx_busy); k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("tx_drain", expTx.size(), 32'h0);
        check("tx_start_count", startCount, 32'd2);
        busRead(2'd1, d);
        check("status_tx_done", d, 32'h0000_0006);

        // TX FIFO overflow while the transmitter stays busy
        modelOn = 1'b0; forceBusy = 1'b1;
        for (int i = 0; i < 17; i++) busWrite(2'd0, 8'h60 + 8'(i));
        busRead(2'd1, d);
        check("status_tx_full_drop", d, 32'h1000_0025);
        busRead(2'd1, d);
        check("status_tx_drop_clr", d, 32'h1000_0005);

        // reset mid-transmission flushes; nothing may start afterwards
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        busRead(2'd1, d);
        check("status_after_flush", d, 32'h0000_0006);
        forceBusy = 1'b0;
        repeat (5) @(negedge clk);
        modelOn = 1'b1;

        // RX overflow: 17 strobes, 16 kept
        for (int i = 0; i < 17; i++) begin
            if (i < 16) expRx.push_back(8'(i));
            rxInject(8'(i));
        end
        busRead(2'd1, d);
        check("status_rx_full_ovr", d, 32'h0010_001A);
        for (int i = 0; i < 17; i++) readData($sformatf("rx_read%0d", i));

        // full RX FIFO, rx_ready coincident with DATA read
        for (int i = 0; i < 16; i++) begin
            expRx.push_back(8'hA0 + 8'(i));
            rxInject(8'hA0 + 8'(i));
        end
        b = expRx.pop_front();
        e = {23'b0, 1'b1, b};
        expRx.push_back(8'hB0);
        bus_en = 1'b1; bus_we = 1'b0; bus_addr = 2'd0; rx_ready = 1'b1; rx_data = 8'hB0;
        @(negedge clk);
        bus_en = 1'b0; rx_ready = 1'b0;
        check("rx_read_with_push", bus_rdata, e);
        busRead(2'd1, d);
        check("status_no_overrun", d, 32'h0010_000A);

        // overrun event coincident with a clearing STATUS read: set wins
        bus_en = 1'b1; bus_we = 1'b0; bus_addr = 2'd1; rx_ready = 1'b1; rx_data = 8'hD0;
        @(negedge clk);
        bus_en = 1'b0; rx_ready = 1'b0;
        check("status_coincident", bus_rdata, 32'h0010_000A);
        busRead(2'd1, d);
        check("overrun_set_wins", d, 32'h0010_001A);
        busRead(2'd1, d);
        check("overrun_cleared", d, 32'h0010_000A);
        for (int i = 0; i < 16; i++) readData($sformatf("rx_drain%0d", i));
        busRead(2'd1, d);
        check("status_rx_drained", d, 32'h0000_0006);

`ifdef UART_IRQ_EN
        busWrite(2'd2, 8'h01);
        expRx.push_back(8'h55);
        rxInject(8'h55);
        @(negedge clk);
        check("irq_rx_set", {31'b0, irq}, 32'h1);
        readData("irq_rx_read");
        check("irq_rx_lag", {31'b0, irq}, 32'h1);
        @(negedge clk);
        check("irq_rx_drop", {31'b0, irq}, 32'h0);
        busWrite(2'd2, 8'h02);
        @(negedge clk);
        check("irq_tx_empty", {31'b0, irq}, 32'h1);
        busWrite(2'd2, 8'h00);
        @(negedge clk);
        check("irq_tx_off", {31'b0, irq}, 32'h0);
`else
        busWrite(2'd2, 8'h01);
        expRx.push_back(8'h55);
        rxInject(8'h55);
        repeat (2) @(negedge clk);
        check("irq_tied_low", {31'b0, irq}, 32'h0);
        busRead(2'd2, d);
        check("ctrl_reads_zero", d, 32'h0);
        readData("rx_read_55");
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
